// File: rtl/dbus_arbiter_pkg.sv
// Shared constants for the data-bus arbiter: slave address windows,
// slave-select bit positions and master indices.
package dbus_arbiter_pkg;

    // Slave address windows, inclusive base and limit
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
    localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] T0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] T1_LIMIT = 32'h0000_7F1B;
    localparam logic [31:0] IG_BASE  = 32'h0000_7F20;
    localparam logic [31:0] IG_LIMIT = 32'h0000_7F23;

    // Word index (addr[3:2]) of the read-only timer register at offset 0x8;
    // both timer bases are 16-byte aligned, so this holds for either timer
    localparam logic [1:0] TIMER_RO_WORD = 2'b10;

    // Bit positions inside the one-hot slave select
    localparam int SEL_DM = 0;
    localparam int SEL_T0 = 1;
    localparam int SEL_T1 = 2;
    localparam int SEL_IG = 3;

    // Master indices into the request/grant/response vectors
    localparam int MST_CPU = 0;
    localparam int MST_DMA = 1;

    // True when addr lies in the inclusive window [base, limit]
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/dbus_arbiter_decode.sv
// Address decoder and access-legality checker for the granted request.
// Illegal accesses produce an all-zero select so nothing reaches a slave.
module dbus_decode
    import dbus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic        we,
    output logic [3:0]  sel,
    output logic        illegal
);

    logic [3:0] hit;
    logic       is_timer;
    logic       misaligned;
    logic       timer_partial;
    logic       timer_ro_write;

    // Decode the address window, then flag any rule the access breaks
    always_comb begin
        hit            = '0;
        hit[SEL_DM]    = in_range(addr, DM_BASE, DM_LIMIT);
        hit[SEL_T0]    = in_range(addr, T0_BASE, T0_LIMIT);
        hit[SEL_T1]    = in_range(addr, T1_BASE, T1_LIMIT);
        hit[SEL_IG]    = in_range(addr, IG_BASE, IG_LIMIT);

        is_timer       = hit[SEL_T0] | hit[SEL_T1];
        misaligned     = (byteen == 4'hF) && (addr[1:0] != 2'b00);
        timer_partial  = is_timer && (byteen != 4'hF);
        timer_ro_write = we && is_timer && (addr[3:2] == TIMER_RO_WORD);

        illegal        = (hit == 4'b0000) | misaligned | timer_partial | timer_ro_write;
        sel            = illegal ? 4'b0000 : hit;
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (CPU M-stage and DMA) in front of the data
// memory, two timers and the interrupt generator. CPU has priority, but a
// starvation counter hands the bus to a waiting DMA after STARVE_MAX
// consecutive CPU grants. One-cycle response pipeline overlaps with the
// next grant, so the bus sustains one transfer per cycle.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_byteen,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_rvalid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_err,
    output logic [3:0]  ds_sel,
    output logic [31:0] ds_addr,
    output logic [31:0] ds_wdata,
    output logic [3:0]  ds_byteen,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] t0_rdata,
    input  logic [31:0] t1_rdata,
    input  logic [31:0] ig_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_owner_q, rsp_owner_d;
    logic [3:0]       rsp_sel_q, rsp_sel_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_we_q, rsp_we_d;

    logic [1:0]  gnt;
    logic        any_gnt;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_byteen;
    logic        g_we;
    logic [3:0]  dec_sel;
    logic        dec_illegal;

    // Pick the winning master: DMA only when CPU is idle or DMA has starved
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (m_req[MST_DMA] && (!m_req[MST_CPU] || (starve_q == STARVE_LIMIT))) begin
                gnt[MST_DMA] = 1'b1;
            end else if (m_req[MST_CPU]) begin
                gnt[MST_CPU] = 1'b1;
            end
        end
        any_gnt = |gnt;
        m_gnt   = gnt;
    end

    // Route the granted master's request fields onto the shared bus
    always_comb begin
        if (gnt[MST_DMA]) begin
            g_addr   = m_addr[63:32];
            g_wdata  = m_wdata[63:32];
            g_byteen = m_byteen[7:4];
            g_we     = m_we[MST_DMA];
        end else begin
            g_addr   = m_addr[31:0];
            g_wdata  = m_wdata[31:0];
            g_byteen = m_byteen[3:0];
            g_we     = m_we[MST_CPU];
        end
    end

    dbus_decode u_decode (
        .addr    (g_addr),
        .byteen  (g_byteen),
        .we      (g_we),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    // Drive the slave side; select and byte enables only for legal grants
    always_comb begin
        ds_addr   = g_addr;
        ds_wdata  = g_wdata;
        ds_sel    = any_gnt ? dec_sel : 4'b0000;
        ds_byteen = (any_gnt && g_we && !dec_illegal) ? g_byteen : 4'b0000;
    end

    // Count CPU wins while DMA waits; clear once DMA is served or stops asking
    always_comb begin
        starve_d = starve_q;
        if (gnt[MST_DMA] || !m_req[MST_DMA]) begin
            starve_d = '0;
        end else if (gnt[MST_CPU] && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Capture what the response cycle needs; the write flag lets writes ack with zero data
    always_comb begin
        rsp_valid_d = any_gnt;
        rsp_owner_d = gnt[MST_DMA];
        rsp_sel_d   = ds_sel;
        rsp_err_d   = any_gnt & dec_illegal;
        rsp_we_d    = any_gnt & g_we;
    end

    // State registers; reset also drops any response still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_sel_q   <= 4'b0000;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    // Return the response to its owner; data only for successful reads
    always_comb begin
        m_rvalid = 2'b00;
        m_err    = 2'b00;
        m_rdata  = 32'h0;
        if (rsp_valid_q) begin
            m_rvalid[rsp_owner_q] = 1'b1;
            m_err[rsp_owner_q]    = rsp_err_q;
            if (!rsp_err_q && !rsp_we_q) begin
                m_rdata = ({32{rsp_sel_q[SEL_DM]}} & dm_rdata) |
                          ({32{rsp_sel_q[SEL_T0]}} & t0_rdata) |
                          ({32{rsp_sel_q[SEL_T1]}} & t1_rdata) |
                          ({32{rsp_sel_q[SEL_IG]}} & ig_rdata);
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a
// transaction-level model of the arbitration and decode rules.
module tb_dbus_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_byteen;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_err;
    logic [3:0]  ds_sel;
    logic [31:0] ds_addr;
    logic [31:0] ds_wdata;
    logic [3:0]  ds_byteen;
    logic [31:0] dm_rdata;
    logic [31:0] t0_rdata;
    logic [31:0] t1_rdata;
    logic [31:0] ig_rdata;

    int checks   = 0;
    int failures = 0;

    // Model state: the DMA wait streak and the one outstanding response
    int modelStreak = 0;
    bit live        = 1'b0;
    bit pendValid   = 1'b0;
    int pendOwner   = 0;
    bit pendErr     = 1'b0;
    bit pendWrite   = 1'b0;
    int pendSlave   = -1;

    always #5 clk = ~clk;

    dbus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byteen  (m_byteen),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .ds_sel    (ds_sel),
        .ds_addr   (ds_addr),
        .ds_wdata  (ds_wdata),
        .ds_byteen (ds_byteen),
        .dm_rdata  (dm_rdata),
        .t0_rdata  (t0_rdata),
        .t1_rdata  (t1_rdata),
        .ig_rdata  (ig_rdata)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic rst, input logic [1:0] req,
                                 input logic [1:0] we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] be);
        @(posedge clk);
        #1;
        reset    = rst;
        m_req    = req;
        m_we     = we;
        m_addr   = addr;
        m_wdata  = wdata;
        m_byteen = be;
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b11, 2'b00, {32'h10, 32'h10}, 64'h0, 8'hFF);
        applyStimulus(1'b1, 2'b11, 2'b00, {32'h10, 32'h10}, 64'h0, 8'hFF);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
    endtask

    // Which slave an address belongs to: 0 DM, 1 Timer0, 2 Timer1, 3 IG, -1 none
    function automatic int slaveOf(input logic [31:0] a);
        if (a <= 32'h2FFF) return 0;
        if (a >= 32'h7F00 && a <= 32'h7F0B) return 1;
        if (a >= 32'h7F10 && a <= 32'h7F1B) return 2;
        if (a >= 32'h7F20 && a <= 32'h7F23) return 3;
        return -1;
    endfunction

    function automatic bit illegalAccess(input logic [31:0] a, input logic [3:0] be,
                                         input logic we);
        int s;
        bit timer;
        int off;
        s     = slaveOf(a);
        timer = (s == 1) || (s == 2);
        off   = timer ? int'(a - ((s == 1) ? 32'h7F00 : 32'h7F10)) : 0;
        if (s < 0) return 1'b1;
        if (be == 4'hF && (a % 4) != 0) return 1'b1;
        if (timer && be != 4'hF) return 1'b1;
        if (timer && we && off >= 8) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] slaveData(input int s);
        case (s)
            0:       return dm_rdata;
            1:       return t0_rdata;
            2:       return t1_rdata;
            3:       return ig_rdata;
            default: return 32'h0;
        endcase
    endfunction

    // Compare the registered outputs against the response owed from last cycle
    task automatic checkResponse();
        logic [1:0]  expValid;
        logic [1:0]  expErr;
        logic [31:0] expData;
        expValid = pendValid ? ((pendOwner == 1) ? 2'b10 : 2'b01) : 2'b00;
        expErr   = (pendValid && pendErr) ? expValid : 2'b00;
        expData  = (pendValid && !pendErr && !pendWrite) ? slaveData(pendSlave) : 32'h0;
        checkOutput("m_rvalid", 64'(m_rvalid), 64'(expValid));
        checkOutput("m_err", 64'(m_err), 64'(expErr));
        checkOutput("m_rdata", 64'(m_rdata), 64'(expData));
    endtask

    // Every-cycle comparison against the model, then advance the model
    always @(negedge clk) begin : compare
        logic [1:0]  expGnt;
        int          who;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
        bit          bad;
        int          s;
        logic [3:0]  expSel;
        logic [3:0]  expBe;
        if (reset === 1'b1) begin
            checkOutput("gnt_in_reset", 64'(m_gnt), 64'h0);
            checkOutput("ds_sel_in_reset", 64'(ds_sel), 64'h0);
            checkOutput("ds_byteen_in_reset", 64'(ds_byteen), 64'h0);
            if (live) checkResponse();
            pendValid   = 1'b0;
            modelStreak = 0;
            live        = 1'b1;
        end else if (live) begin
            checkResponse();
            if (m_req == 2'b11) expGnt = (modelStreak >= STARVE_MAX) ? 2'b10 : 2'b01;
            else                expGnt = m_req;
            checkOutput("m_gnt", 64'(m_gnt), 64'(expGnt));
            who = expGnt[1] ? 1 : 0;
            a   = (who == 1) ? m_addr[63:32]   : m_addr[31:0];
            wd  = (who == 1) ? m_wdata[63:32]  : m_wdata[31:0];
            be  = (who == 1) ? m_byteen[7:4]   : m_byteen[3:0];
            we  = m_we[who];
            if (expGnt != 2'b00) begin
                bad    = illegalAccess(a, be, we);
                s      = slaveOf(a);
                expSel = bad ? 4'b0000 : 4'(1 << s);
                expBe  = (!bad && we) ? be : 4'b0000;
                checkOutput("ds_sel", 64'(ds_sel), 64'(expSel));
                checkOutput("ds_byteen", 64'(ds_byteen), 64'(expBe));
                checkOutput("ds_addr", 64'(ds_addr), 64'(a));
                checkOutput("ds_wdata", 64'(ds_wdata), 64'(wd));
                pendValid = 1'b1;
                pendOwner = who;
                pendErr   = bad;
                pendWrite = we;
                pendSlave = s;
            end else begin
                checkOutput("ds_sel_idle", 64'(ds_sel), 64'h0);
                checkOutput("ds_byteen_idle", 64'(ds_byteen), 64'h0);
                pendValid = 1'b0;
            end
            if (expGnt == 2'b10 || !m_req[1]) modelStreak = 0;
            else if (expGnt == 2'b01)         modelStreak = (modelStreak + 1 > STARVE_MAX) ? STARVE_MAX : modelStreak + 1;
        end
    end

    function automatic logic [31:0] pickAddr();
        logic [31:0] addrTable [12];
        int r;
        addrTable = '{32'h0, 32'h2FFC, 32'h3000, 32'h7F00, 32'h7F08, 32'h7F0C,
                      32'h7F10, 32'h7F18, 32'h7F1C, 32'h7F20, 32'h7F24, 32'h7EFC};
        r = $urandom_range(0, 3);
        if (r == 0) return 32'($urandom_range(0, 32'h2FFF));
        if (r == 1) return 32'($urandom);
        return addrTable[$urandom_range(0, 11)] + (($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(0, 3)));
    endfunction

    function automatic logic [3:0] pickBe();
        return ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [1:0] starveSeq [10];
        logic [1:0] rq;
        starveSeq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        reset    = 1'b1;
        m_req    = 2'b00;
        m_we     = 2'b00;
        m_addr   = 64'h0;
        m_wdata  = 64'h0;
        m_byteen = 8'h00;
        dm_rdata = 32'h0;
        t0_rdata = 32'h7F00_0000;
        t1_rdata = 32'hAAAA_0001;
        ig_rdata = 32'hBBBB_0002;

        // Reset state and a plain CPU read from data memory
        doReset();
        sampleNow();
        checkOutput("post_reset_rvalid", 64'(m_rvalid), 64'h0);
        checkOutput("post_reset_err", 64'(m_err), 64'h0);
        checkOutput("post_reset_rdata", 64'(m_rdata), 64'h0);
        dm_rdata = 32'h1234_5678;
        applyStimulus(1'b0, 2'b01, 2'b00, {32'h0, 32'h0000_0010}, 64'h0, 8'h0F);
        sampleNow();
        checkOutput("cpu_read_gnt", 64'(m_gnt), 64'h1);
        checkOutput("cpu_read_sel", 64'(ds_sel), 64'h1);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();
        checkOutput("cpu_read_rvalid", 64'(m_rvalid), 64'h1);
        checkOutput("cpu_read_rdata", 64'(m_rdata), 64'h1234_5678);
        checkOutput("cpu_read_err", 64'(m_err), 64'h0);

        // Both masters request continuously: four CPU grants then one DMA
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, {32'h24, 32'h20}, 64'h0, 8'hFF);
            sampleNow();
            checkOutput($sformatf("starve_gnt%0d", i), 64'(m_gnt), 64'(starveSeq[i]));
        end

        // CPU byte store to a timer is illegal
        applyStimulus(1'b0, 2'b01, 2'b01, {32'h0, 32'h7F04}, 64'h55, 8'h01);
        sampleNow();
        checkOutput("timer_sb_gnt", 64'(m_gnt), 64'h1);
        checkOutput("timer_sb_sel", 64'(ds_sel), 64'h0);
        checkOutput("timer_sb_byteen", 64'(ds_byteen), 64'h0);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();
        checkOutput("timer_sb_err", 64'(m_err), 64'h1);
        checkOutput("timer_sb_rvalid", 64'(m_rvalid), 64'h1);

        // DMA store to the timer offset 0x8 and DMA load from unmapped space
        applyStimulus(1'b0, 2'b10, 2'b10, {32'h7F18, 32'h0}, {32'h99, 32'h0}, 8'hF0);
        sampleNow();
        checkOutput("dma_sw_gnt", 64'(m_gnt), 64'h2);
        applyStimulus(1'b0, 2'b10, 2'b00, {32'h3000, 32'h0}, 64'h0, 8'hF0);
        sampleNow();
        checkOutput("dma_sw_err", 64'(m_err), 64'h2);
        checkOutput("dma_sw_rvalid", 64'(m_rvalid), 64'h2);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();
        checkOutput("dma_lw_err", 64'(m_err), 64'h2);
        checkOutput("dma_lw_rdata", 64'(m_rdata), 64'h0);

        // Back-to-back reads from Timer1 then the interrupt generator
        applyStimulus(1'b0, 2'b01, 2'b00, {32'h0, 32'h7F10}, 64'h0, 8'h0F);
        sampleNow();
        checkOutput("b2b_sel_t1", 64'(ds_sel), 64'h4);
        applyStimulus(1'b0, 2'b10, 2'b00, {32'h7F20, 32'h0}, 64'h0, 8'hF0);
        sampleNow();
        checkOutput("b2b_gnt_dma", 64'(m_gnt), 64'h2);
        checkOutput("b2b_sel_ig", 64'(ds_sel), 64'h8);
        checkOutput("b2b_rvalid1", 64'(m_rvalid), 64'h1);
        checkOutput("b2b_rdata1", 64'(m_rdata), 64'hAAAA_0001);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();
        checkOutput("b2b_rvalid2", 64'(m_rvalid), 64'h2);
        checkOutput("b2b_rdata2", 64'(m_rdata), 64'hBBBB_0002);

        // Same pair, but reset lands on the second grant and kills its response
        applyStimulus(1'b0, 2'b01, 2'b00, {32'h0, 32'h7F10}, 64'h0, 8'h0F);
        applyStimulus(1'b1, 2'b10, 2'b00, {32'h7F20, 32'h0}, 64'h0, 8'hF0);
        sampleNow();
        checkOutput("rst_mid_gnt", 64'(m_gnt), 64'h0);
        checkOutput("rst_mid_rvalid", 64'(m_rvalid), 64'h1);
        checkOutput("rst_mid_rdata", 64'(m_rdata), 64'hAAAA_0001);
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();
        checkOutput("rst_after_rvalid", 64'(m_rvalid), 64'h0);
        checkOutput("rst_after_rdata", 64'(m_rdata), 64'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 1500; i++) begin
            rq = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rq = 2'b11;
            applyStimulus(($urandom_range(0, 60) == 0), rq, 2'($urandom_range(0, 3)),
                          {pickAddr(), pickAddr()}, {32'($urandom), 32'($urandom)},
                          {pickBe(), pickBe()});
            dm_rdata = 32'($urandom);
            t0_rdata = 32'($urandom);
            t1_rdata = 32'($urandom);
            ig_rdata = 32'($urandom);
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 8'h00);
        sampleNow();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, both named as in the rest of the CPU: clk (rising edge) and reset.
REQ-002 Parameter STARVE_MAX, default 4: consecutive CPU grants allowed while DMA is waiting.
REQ-003 Ports, listed as name / direction / width / meaning:
- clk / in / 1 / clock
- reset / in / 1 / sync active-high reset
- m_req / in / 2 / request; bit0 = CPU M-stage, bit1 = DMA
- m_we / in / 2 / write enable per master
- m_addr / in / 64 / byte address; [31:0] CPU, [63:32] DMA
- m_wdata / in / 64 / write data, same packing
- m_byteen / in / 8 / byte enables; [3:0] CPU, [7:4] DMA
- m_gnt / out / 2 / one-hot grant, combinational, same cycle as the request
- m_rvalid / out / 2 / response valid, one cycle after grant
- m_rdata / out / 32 / read data, qualified by m_rvalid
- m_err / out / 2 / error response (unmapped address or illegal access)
- ds_sel / out / 4 / one-hot slave select: bit0 DM, bit1 Timer0, bit2 Timer1, bit3 interrupt generator
- ds_addr / out / 32 / forwarded address
- ds_wdata / out / 32 / forwarded write data
- ds_byteen / out / 4 / forwarded byte enables; 0 unless a legal write
- dm_rdata, t0_rdata, t1_rdata, ig_rdata / in / 32 each / slave read data, valid the cycle after select

Function
REQ-004 Address decode SHALL be:
- DM: 0x0000_0000–0x0000_2FFF
- Timer0: 0x7F00–0x7F0B
- Timer1: 0x7F10–0x7F1B
- interrupt generator: 0x7F20–0x7F23
- any other address: unmapped
REQ-005 Exactly one master SHALL be granted per cycle when any m_req is high; m_gnt SHALL be 0 when none is.
REQ-006 Default priority SHALL be CPU over DMA.
REQ-007 A saturating starvation counter SHALL increment on each cycle where the CPU is granted while m_req[1]=1.
REQ-008 The starvation counter SHALL clear whenever DMA is granted or m_req[1]=0.
REQ-009 When the starvation counter equals STARVE_MAX and both masters request, DMA SHALL win that cycle and the CPU SHALL see m_gnt[0]=0.
REQ-010 The granted master's addr, wdata and we SHALL drive ds_* combinationally; ds_sel SHALL be the decoded one-hot of the granted address.
REQ-011 Illegal accesses SHALL be: unmapped address; non-word-aligned word (byteen=4'hF) access; byteen other than 4'hF to a timer; write to timer offset 0x8 (Timer0 or Timer1).
REQ-012 On an illegal access the grant SHALL still be issued, ds_sel and ds_byteen SHALL be 0, and the response cycle SHALL assert m_err.
REQ-013 Response stage registers SHALL be: valid, owner (1 bit), latched ds_sel, err. In the cycle after a grant:
- m_rvalid[owner] = 1
- m_err[owner] = registered err
- m_rdata = rdata of the latched slave, or 0 on err or on writes
REQ-014 A new grant and the previous response SHALL overlap in the same cycle, giving full throughput of one transfer per cycle.
REQ-015 Writes SHALL also return m_rvalid as an acknowledge, with m_rdata=0.
REQ-016 When m_req drops after a grant, the pending response SHALL still complete and the counter SHALL clear per REQ-008.

Reset
REQ-017 While reset is high at a clk edge: starvation counter=0, response valid=0, owner=0, latched sel=0, err=0.
REQ-018 Outputs SHALL read 0 in the cycle after reset: m_rvalid=0, m_err=0, m_rdata=0.
REQ-019 m_gnt, ds_sel and ds_byteen SHALL be forced to 0 while reset is high; any in-flight response SHALL be discarded.

Structure
REQ-020 The shared package SHALL hold:
- address-range constants (DM, Timer0, Timer1, IG base/limit)
- slave-index constants (SEL_DM..SEL_IG)
- master-index constants (MST_CPU=0, MST_DMA=1)
REQ-021 Decode and legality checking SHALL be one combinational sub-module, dbus_decode (addr, byteen, we in; sel, illegal out), instantiated once on the granted request.

Verification
REQ-022 Reset, then CPU read at 0x0000_0010 with dm_rdata=0x1234_5678 -> m_gnt=01, ds_sel=0001; next cycle m_rvalid=01, m_rdata=0x1234_5678, m_err=00.
REQ-023 Both masters request continuously, STARVE_MAX=4 -> grant sequence CPU, CPU, CPU, CPU, DMA, repeating; no cycle without a grant.
REQ-024 CPU sb (byteen=0001) to 0x7F04 -> ds_sel=0, ds_byteen=0; next cycle m_err=01, m_rvalid=01.
REQ-025 DMA sw to 0x7F18 -> m_err[1]=1. DMA lw from 0x0000_3000 -> m_err[1]=1, m_rdata=0.
REQ-026 Back-to-back CPU read of 0x7F10 then DMA read of 0x7F20 -> responses in consecutive cycles returning t1_rdata then ig_rdata. Assert reset during the second grant -> no m_rvalid the following cycle.
